// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared constants and helpers for the ID-stage hazard scoreboard and its forwarding muxes.
// Plays the role of the shared mycpu.h header for this slice.
package id_hazard_scoreboard_pkg;

  localparam int unsigned RegAw     = 5;
  localparam int unsigned NReg      = 32;
  localparam int unsigned DefXlen   = 32;
  localparam int unsigned DefNumFwd = 3;

  // Forwarding source order: lower index = younger producer = higher priority.
  localparam int unsigned FwdExe = 0;
  localparam int unsigned FwdMem = 1;
  localparam int unsigned FwdWb  = 2;

  typedef logic [RegAw-1:0] reg_addr_t;

  // One-hot register mask. r0 is never tracked, so its bit is always clear.
  function automatic logic [NReg-1:0] reg_onehot(input reg_addr_t addr, input logic en);
    logic [NReg-1:0] mask;
    mask = '0;
    if (en && addr != '0) begin
      mask[addr] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/id_hazard_scoreboard_fwd_mux.sv
// Priority forwarding mux for one source operand: the youngest matching producer wins,
// otherwise the regfile value passes through.
module id_fwd_mux
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN    = DefXlen,
  parameter int unsigned NUM_FWD = DefNumFwd
) (
  input  logic                     need,
  input  reg_addr_t                addr,
  input  logic [XLEN-1:0]          rf_data,
  input  logic [NUM_FWD-1:0]       fwd_valid,
  input  logic [NUM_FWD*RegAw-1:0] fwd_addr,
  input  logic [NUM_FWD-1:0]       fwd_ready,
  input  logic [NUM_FWD*XLEN-1:0]  fwd_data,
  output logic [XLEN-1:0]          data,
  output logic                     hit,
  output logic                     not_ready
);

  always_comb begin
    data      = rf_data;
    hit       = 1'b0;
    not_ready = 1'b0;
    // r0 reads as zero from the regfile; never let a stray r0 writer shadow it.
    if (need && addr != '0) begin
      for (int j = 0; j < int'(NUM_FWD); j++) begin
        if (!hit && fwd_valid[j] && fwd_addr[j*RegAw +: RegAw] == addr) begin
          hit       = 1'b1;
          data      = fwd_data[j*XLEN +: XLEN];
          not_ready = ~fwd_ready[j];
        end
      end
    end
  end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage pipeline register with operand forwarding, load-use stall and long-latency busy
// scoreboard. Define ID_STALL_CNT_EN to add the stall_cnt performance counter output.
module id_hazard_scoreboard
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN      = DefXlen,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned NUM_FWD   = DefNumFwd,
  parameter int unsigned PAYLOAD_W = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_allowin,
  input  logic [PAYLOAD_W-1:0]     in_payload,
  input  logic                     in_cancel,
  output logic [PAYLOAD_W-1:0]     held_payload,
  input  logic [NUM_SRC-1:0]       src_need,
  input  logic [NUM_SRC*RegAw-1:0] src_addr,
  input  logic                     dst_we,
  input  logic [RegAw-1:0]         dst_addr,
  input  logic                     dst_long,
  input  logic [NUM_SRC*XLEN-1:0]  rf_rdata,
  input  logic [NUM_FWD-1:0]       fwd_valid,
  input  logic [NUM_FWD*RegAw-1:0] fwd_addr,
  input  logic [NUM_FWD-1:0]       fwd_ready,
  input  logic [NUM_FWD*XLEN-1:0]  fwd_data,
  input  logic                     lwb_valid,
  input  logic [RegAw-1:0]         lwb_addr,
  output logic                     out_valid,
  input  logic                     out_allowin,
  output logic [NUM_SRC*XLEN-1:0]  src_data,
  output logic                     stall
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]              stall_cnt
`endif
);

  logic                 valid_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [NReg-1:0]      busy_q, busy_d;
  logic [NReg-1:0]      busy_eff;
  logic [NReg-1:0]      lwb_clr;
  logic [NReg-1:0]      issue_set;
  logic [NUM_SRC-1:0]   fwd_hit;
  logic [NUM_SRC-1:0]   fwd_nrdy;
  logic [NUM_SRC-1:0]   opnd_hazard;
  logic                 waw_hazard;
  logic                 issue_long;

  // A writeback this cycle already resolves the hazard: its data is on a forwarding port.
  assign lwb_clr  = reg_onehot(lwb_addr, lwb_valid);
  assign busy_eff = busy_q & ~lwb_clr;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    reg_addr_t addr;
    assign addr = src_addr[i*RegAw +: RegAw];

    id_fwd_mux #(
      .XLEN   (XLEN),
      .NUM_FWD(NUM_FWD)
    ) u_fwd_mux (
      .need     (src_need[i]),
      .addr     (addr),
      .rf_data  (rf_rdata[i*XLEN +: XLEN]),
      .fwd_valid(fwd_valid),
      .fwd_addr (fwd_addr),
      .fwd_ready(fwd_ready),
      .fwd_data (fwd_data),
      .data     (src_data[i*XLEN +: XLEN]),
      .hit      (fwd_hit[i]),
      .not_ready(fwd_nrdy[i])
    );

    assign opnd_hazard[i] = src_need[i] & (addr != '0)
                          & ((fwd_hit[i] & fwd_nrdy[i]) | busy_eff[addr]);
  end

  assign waw_hazard = dst_we & dst_long & (dst_addr != '0) & busy_eff[dst_addr];

  always_comb begin
    stall        = valid_q & ((|opnd_hazard) | waw_hazard);
    out_valid    = valid_q & ~stall;
    in_allowin   = ~valid_q | (~stall & out_allowin);
    held_payload = payload_q;
  end

  assign issue_long = out_valid & out_allowin & dst_we & dst_long;
  assign issue_set  = reg_onehot(dst_addr, issue_long);

  // Set is applied after clear so a same-cycle set on the same register wins.
  always_comb begin
    busy_d = (busy_q & ~lwb_clr) | issue_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      busy_q  <= '0;
    end else begin
      if (in_allowin) begin
        valid_q <= in_valid & ~in_cancel;
      end
      busy_q <= busy_d;
    end
  end

  // Payload is a plain datapath register; its value is don't-care while invalid.
  always_ff @(posedge clk) begin
    if (in_allowin && in_valid) begin
      payload_q <= in_payload;
    end
  end

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
